// File: rtl/cordic_iter_core.sv
// Iterative CORDIC engine: rotation (polar->rect) or vectoring (rect->polar), one
// micro-rotation per clka cycle, with quadrant pre-rotation and saturated outputs.
module cordic_iter_core #(
  parameter int WIDTH = 16,
  parameter int ITERS = 14,
  parameter int GUARD = 2
) (
  input  logic                    clka,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out,
  output logic                    busy,
  output logic                    done
);

  localparam int XW = WIDTH + 2 + GUARD;
  localparam int ZW = WIDTH + GUARD;
  localparam int CW = $clog2(ITERS + 1);

  localparam logic signed [ZW-1:0] Z_QUARTER = {2'b01, {(ZW-2){1'b0}}};
  localparam logic signed [XW:0]   X_HALF    = (XW+1)'((1 << GUARD) >> 1);
  localparam logic signed [ZW-1:0] Z_HALF    = ZW'((1 << GUARD) >> 1);
  localparam logic signed [XW:0]   SAT_MAX   = (XW+1)'((1 << (WIDTH-1)) - 1);
  localparam logic signed [XW:0]   SAT_MIN   = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                    r_mode;
  logic signed [WIDTH-1:0] r_x_in;
  logic signed [WIDTH-1:0] r_y_in;
  logic signed [WIDTH-1:0] r_z_in;
  logic signed [XW-1:0]    r_x;
  logic signed [XW-1:0]    r_y;
  logic signed [ZW-1:0]    r_z;
  logic [CW-1:0]           r_cnt;
  logic signed [WIDTH-1:0] r_x_out;
  logic signed [WIDTH-1:0] r_y_out;
  logic signed [WIDTH-1:0] r_z_out;
  logic                    r_done;

  logic signed [XW-1:0]    w_x_ext;
  logic signed [XW-1:0]    w_y_ext;
  logic signed [ZW-1:0]    w_z_ext;
  logic signed [XW-1:0]    w_x0;
  logic signed [XW-1:0]    w_y0;
  logic signed [ZW-1:0]    w_z0;
  logic signed [XW-1:0]    w_x_sh;
  logic signed [XW-1:0]    w_y_sh;
  logic signed [ZW-1:0]    w_atan;
  logic                    w_d_pos;
  logic signed [XW-1:0]    w_x_n;
  logic signed [XW-1:0]    w_y_n;
  logic signed [ZW-1:0]    w_z_n;
  logic signed [XW:0]      w_x_rnd;
  logic signed [XW:0]      w_y_rnd;
  logic signed [WIDTH-1:0] w_z_rnd;

  // atan(2^-i) scaled so that 2^32 spans a full turn
  function automatic logic [31:0] atan32(input int unsigned idx);
    case (idx)
      0:  atan32 = 32'h20000000;
      1:  atan32 = 32'h12E4051E;
      2:  atan32 = 32'h09FB385B;
      3:  atan32 = 32'h051111D4;
      4:  atan32 = 32'h028B0D43;
      5:  atan32 = 32'h0145D7E1;
      6:  atan32 = 32'h00A2F61E;
      7:  atan32 = 32'h00517C55;
      8:  atan32 = 32'h0028BE53;
      9:  atan32 = 32'h00145F2F;
      10: atan32 = 32'h000A2F98;
      11: atan32 = 32'h000517CC;
      12: atan32 = 32'h00028BE6;
      13: atan32 = 32'h000145F3;
      14: atan32 = 32'h0000A2FA;
      15: atan32 = 32'h0000517D;
      16: atan32 = 32'h000028BE;
      17: atan32 = 32'h0000145F;
      18: atan32 = 32'h00000A30;
      19: atan32 = 32'h00000518;
      20: atan32 = 32'h0000028C;
      21: atan32 = 32'h00000146;
      22: atan32 = 32'h000000A3;
      23: atan32 = 32'h00000051;
      24: atan32 = 32'h00000029;
      25: atan32 = 32'h00000014;
      26: atan32 = 32'h0000000A;
      27: atan32 = 32'h00000005;
      28: atan32 = 32'h00000003;
      29: atan32 = 32'h00000001;
      30: atan32 = 32'h00000001;
      default: atan32 = '0;
    endcase
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [XW:0] v);
    if (v > SAT_MAX) begin
      sat = WIDTH'(SAT_MAX);
    end else if (v < SAT_MIN) begin
      sat = WIDTH'(SAT_MIN);
    end else begin
      sat = WIDTH'(v);
    end
  endfunction

  assign w_x_ext = XW'(r_x_in) <<< GUARD;
  assign w_y_ext = XW'(r_y_in) <<< GUARD;
  assign w_z_ext = ZW'(r_z_in) <<< GUARD;

  // Fold the operand into the +/-90 degree band the micro-rotations can reach
  always_comb begin
    w_x0 = w_x_ext;
    w_y0 = w_y_ext;
    w_z0 = r_mode ? '0 : w_z_ext;
    if (!r_mode) begin
      case (r_z_in[WIDTH-1 -: 2])
        2'b01: begin
          w_x0 = -w_y_ext;
          w_y0 = w_x_ext;
          w_z0 = w_z_ext - Z_QUARTER;
        end
        2'b10: begin
          w_x0 = w_y_ext;
          w_y0 = -w_x_ext;
          w_z0 = w_z_ext + Z_QUARTER;
        end
        default: ;
      endcase
    end else if (r_x_in[WIDTH-1]) begin
      if (!r_y_in[WIDTH-1]) begin
        w_x0 = w_y_ext;
        w_y0 = -w_x_ext;
        w_z0 = Z_QUARTER;
      end else begin
        w_x0 = -w_y_ext;
        w_y0 = w_x_ext;
        w_z0 = -Z_QUARTER;
      end
    end
  end

  assign w_x_sh  = r_x >>> r_cnt;
  assign w_y_sh  = r_y >>> r_cnt;
  assign w_atan  = ZW'(atan32(32'(r_cnt)) >> (32 - ZW));
  assign w_d_pos = r_mode ? r_y[XW-1] : ~r_z[ZW-1];

  always_comb begin
    w_x_n = r_x + w_y_sh;
    w_y_n = r_y - w_x_sh;
    w_z_n = r_z + w_atan;
    if (w_d_pos) begin
      w_x_n = r_x - w_y_sh;
      w_y_n = r_y + w_x_sh;
      w_z_n = r_z - w_atan;
    end
  end

  // Round-half-up on the guard bits; z wraps naturally as a binary angle
  assign w_x_rnd = ((XW+1)'(r_x) + X_HALF) >>> GUARD;
  assign w_y_rnd = ((XW+1)'(r_y) + X_HALF) >>> GUARD;
  assign w_z_rnd = WIDTH'((r_z + Z_HALF) >>> GUARD);

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        busy   = 1'b1;
        w_next = S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (r_cnt == CW'(ITERS - 1)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_x_in  <= '0;
      r_y_in  <= '0;
      r_z_in  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_cnt   <= '0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_z_out <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode <= mode;
            r_x_in <= x_in;
            r_y_in <= y_in;
            r_z_in <= z_in;
          end
        end
        S_LOAD: begin
          r_x   <= w_x0;
          r_y   <= w_y0;
          r_z   <= w_z0;
          r_cnt <= '0;
        end
        S_ITER: begin
          r_x   <= w_x_n;
          r_y   <= w_y_n;
          r_z   <= w_z_n;
          r_cnt <= r_cnt + CW'(1);
        end
        S_DONE: begin
          r_x_out <= sat(w_x_rnd);
          r_y_out <= sat(w_y_rnd);
          r_z_out <= w_z_rnd;
          r_done  <= 1'b1;
          r_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign x_out = r_x_out;
  assign y_out = r_y_out;
  assign z_out = r_z_out;
  assign done  = r_done;

endmodule

// File: tb/tb_cordic_iter_core.sv
// Scoreboard bench for cordic_iter_core: expected results come from an ideal
// floating-point rotation/vectoring model scaled by the uncompensated CORDIC gain.
module tb_cordic_iter_core;

  localparam int  W  = 16;
  localparam int  N  = 14;
  localparam int  G  = 2;
  localparam real PI = 3.14159265358979;

  logic                clka = 1'b0;
  logic                reset;
  logic                start;
  logic                mode;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_in;
  logic signed [W-1:0] z_in;
  logic signed [W-1:0] x_out;
  logic signed [W-1:0] y_out;
  logic signed [W-1:0] z_out;
  logic                busy;
  logic                done;

  typedef struct {
    int xe;
    int ye;
    int ze;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  real  K;

  cordic_iter_core #(
    .WIDTH(W),
    .ITERS(N),
    .GUARD(G)
  ) dut (
    .clka (clka),
    .reset(reset),
    .start(start),
    .mode (mode),
    .x_in (x_in),
    .y_in (y_in),
    .z_in (z_in),
    .x_out(x_out),
    .y_out(y_out),
    .z_out(z_out),
    .busy (busy),
    .done (done)
  );

  always #5 clka = ~clka;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check_result(input string tag, input int obs, input int expv,
                              input int tol, input bit wrap);
    int d;
    logic signed [15:0] t;
    n_tests++;
    d = obs - expv;
    if (wrap) begin
      t = d[15:0];
      d = t;
    end
    if (d > tol || d < -tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, expv, tol);
    end
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic exp_t model(input bit md, input int x, input int y, input int z);
    exp_t e;
    real  a;
    real  xr;
    real  yr;
    real  zr;
    if (!md) begin
      a  = real'(z) * 2.0 * PI / 65536.0;
      xr = K * (real'(x) * $cos(a) - real'(y) * $sin(a));
      yr = K * (real'(y) * $cos(a) + real'(x) * $sin(a));
      zr = 0.0;
    end else begin
      xr = K * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      yr = 0.0;
      zr = $atan2(real'(y), real'(x)) * 65536.0 / (2.0 * PI);
    end
    e.xe = clamp16(rnd(xr));
    e.ye = clamp16(rnd(yr));
    e.ze = rnd(zr);
    return e;
  endfunction

  // poke: 0 none, 1 start pulse mid-ITER, 2 start pulse during the DONE state
  task automatic run_op(input string tag, input bit md, input logic signed [15:0] x,
                        input logic signed [15:0] y, input logic signed [15:0] z,
                        input int poke, input int xy_tol, input int z_tol);
    exp_t e;
    int   lat;
    bit   got;
    @(negedge clka);
    mode  = md;
    x_in  = x;
    y_in  = y;
    z_in  = z;
    start = 1'b1;
    sb.push_back(model(md, x, y, z));
    @(posedge clka);
    #1;
    start = 1'b0;
    x_in  = 16'($urandom);
    y_in  = 16'($urandom);
    z_in  = 16'($urandom);
    mode  = ~md;
    check_result({tag, "_busy"}, int'(busy), 1, 0, 1'b0);
    lat = 0;
    got = 1'b0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(posedge clka);
      #1;
      if (done) begin
        got   = 1'b1;
        lat   = n;
        start = 1'b0;
      end else begin
        if (n == N + 1) check_result({tag, "_busy_done"}, int'(busy), 0, 0, 1'b0);
        start = (poke == 1 && n == 5) || (poke == 2 && n == N + 1);
      end
    end
    start = 1'b0;
    check_result({tag, "_lat"}, lat, N + 2, 0, 1'b0);
    e = sb.pop_front();
    check_result({tag, "_x"}, int'(x_out), e.xe, xy_tol, 1'b0);
    check_result({tag, "_y"}, int'(y_out), e.ye, xy_tol, 1'b0);
    check_result({tag, "_z"}, int'(z_out), e.ze, z_tol, 1'b1);
    @(posedge clka);
    #1;
    check_result({tag, "_done_w"}, int'(done), 0, 0, 1'b0);
    check_result({tag, "_idle"}, int'(busy), 0, 0, 1'b0);
    check_result({tag, "_hold_x"}, int'(x_out), e.xe, xy_tol, 1'b0);
  endtask

  initial begin
    exp_t e;
    int   d1;
    int   d2;
    int   cnt;
    int   mx;
    int   my;

    K = 1.0;
    for (int i = 0; i < N; i++) K = K * $sqrt(1.0 + $pow(2.0, -2.0 * i));

    reset = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    x_in  = '0;
    y_in  = '0;
    z_in  = '0;
    repeat (3) @(posedge clka);
    #1;
    check_result("rst_x", int'(x_out), 0, 0, 1'b0);
    check_result("rst_y", int'(y_out), 0, 0, 1'b0);
    check_result("rst_z", int'(z_out), 0, 0, 1'b0);
    check_result("rst_busy", int'(busy), 0, 0, 1'b0);
    check_result("rst_done", int'(done), 0, 0, 1'b0);
    @(negedge clka);
    reset = 1'b0;

    run_op("rot45", 1'b0, 16'sd8192, 16'sd0, 16'sh2000, 0, 4, 2);
    run_op("rot90", 1'b0, 16'sd8192, 16'sd0, 16'sh4000, 0, 4, 2);
    run_op("vec45", 1'b1, 16'sd8192, 16'sd8192, 16'sh0000, 0, 4, 2);
    run_op("vec180", 1'b1, -16'sd8192, 16'sd0, 16'sh1234, 0, 4, 2);
    run_op("vec_sat", 1'b1, 16'sd32767, 16'sd32767, 16'sh0000, 0, 4, 2);
    run_op("rotm90", 1'b0, 16'sd8192, 16'sd0, 16'shC000, 0, 4, 2);
    run_op("rot_m135", 1'b0, 16'sd8000, 16'sd3000, 16'shA000, 0, 4, 2);
    run_op("vec_q3", 1'b1, -16'sd6000, -16'sd9000, 16'sh0000, 0, 4, 2);
    run_op("poke_iter", 1'b0, 16'sd7000, -16'sd2000, 16'sh3000, 1, 4, 2);
    run_op("poke_done", 1'b1, 16'sd5000, -16'sd7000, 16'sh0000, 2, 4, 2);

    // Abort mid-ITER: async reset must clear everything without waiting for an edge
    @(negedge clka);
    mode  = 1'b0;
    x_in  = 16'sd8192;
    y_in  = 16'sd4000;
    z_in  = 16'sh1000;
    start = 1'b1;
    @(posedge clka);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clka);
    #3;
    reset = 1'b1;
    #1;
    check_result("abort_x", int'(x_out), 0, 0, 1'b0);
    check_result("abort_y", int'(y_out), 0, 0, 1'b0);
    check_result("abort_z", int'(z_out), 0, 0, 1'b0);
    check_result("abort_busy", int'(busy), 0, 0, 1'b0);
    check_result("abort_done", int'(done), 0, 0, 1'b0);
    @(negedge clka);
    reset = 1'b0;
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clka);
      #1;
      if (done || busy) cnt++;
    end
    check_result("abort_quiet", cnt, 0, 0, 1'b0);
    run_op("post_rst", 1'b0, 16'sd8192, 16'sd4000, 16'sh1000, 0, 4, 2);

    // start held high: second operation begins on the first IDLE cycle after DONE
    @(negedge clka);
    mode  = 1'b0;
    x_in  = 16'sd6000;
    y_in  = -16'sd3000;
    z_in  = 16'sh1800;
    start = 1'b1;
    e = model(1'b0, 6000, -3000, 6144);
    sb.push_back(e);
    sb.push_back(e);
    @(posedge clka);
    d1 = 0;
    d2 = 0;
    for (int n = 1; n <= 60 && d2 == 0; n++) begin
      @(posedge clka);
      #1;
      if (n == N + 3) start = 1'b0;
      if (done) begin
        if (d1 == 0) d1 = n;
        else d2 = n;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_result("b2b_x", int'(x_out), e.xe, 4, 1'b0);
          check_result("b2b_y", int'(y_out), e.ye, 4, 1'b0);
          check_result("b2b_z", int'(z_out), e.ze, 2, 1'b1);
        end
      end
    end
    start = 1'b0;
    sb.delete();
    check_result("b2b_first", d1, N + 2, 0, 1'b0);
    check_result("b2b_second", d2, 2 * N + 5, 0, 1'b0);
    repeat (3) @(posedge clka);

    for (int k = 0; k < 6; k++) begin
      mx = int'($urandom_range(0, 24000)) - 12000;
      my = int'($urandom_range(0, 24000)) - 12000;
      run_op("rot_rnd", 1'b0, 16'(mx), 16'(my), 16'($urandom), 0, 4, 3);
    end
    for (int k = 0; k < 6; k++) begin
      mx = int'($urandom_range(4000, 12000));
      my = int'($urandom_range(4000, 12000));
      if ($urandom_range(0, 1) == 1) mx = -mx;
      if ($urandom_range(0, 1) == 1) my = -my;
      run_op("vec_rnd", 1'b1, 16'(mx), 16'(my), 16'($urandom), 0, 4, 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
